reg_bus_initiator: RTL and testbench
====================================

Name: reg_bus_initiator

Overview:
- Synchronous initiator for the asynchronous register bus (en/rd/wr/be/addr/data) used by the register file blocks (primary and tile register banks).
- Converts a single-transaction valid/ready request from a host-side bridge (SPI/MCU front end) into correctly timed bus strobes with programmable setup, strobe and hold phases.
- Returns read data and a completion pulse.
- Sits between the host bridge and the register file. The register file's write edge is the falling edge of wr; its read latch is the rising edge of en&rd.

Parameters:
- ADDR_WIDTH, 16, register address width.
- DATA_WIDTH, 16, data bus width.
- SETUP_CYCLES, 1, clk cycles that en/addr/data/be are stable before the strobe rises; legal range 1..255.
- STROBE_CYCLES, 2, clk cycles that rd or wr is held high; legal range 1..255.
- HOLD_CYCLES, 1, clk cycles that en/addr/data/be stay stable after the strobe falls; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  initiator can accept a request (high only in IDLE)
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  target register address
- req_data  in  DATA_WIDTH  write data
- req_be  in  2  byte enables; [0]=low byte, [1]=high byte
- done  out  1  one-cycle completion pulse, for both reads and writes
- rdata  out  DATA_WIDTH  read data; valid when done follows a read
- bus_en  out  1  bus access enable
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- bus_be  out  2  bus byte enables
- bus_addr  out  ADDR_WIDTH  bus address
- bus_data_out  out  DATA_WIDTH  bus write data
- bus_data_in  in  DATA_WIDTH  bus read data from the register file

Behaviour:
- Reset is synchronous and active-high. Values at the first edge with reset=1:
  - state=IDLE
  - bus_en, bus_rd, bus_wr = 0
  - bus_be=0, bus_addr=0, bus_data_out=0
  - rdata=0, done=0, req_ready=1
- Request handshake:
  - A request is accepted on the edge where req_valid & req_ready.
  - req_* fields are registered into bus_addr, bus_data_out, bus_be and an internal is_write flag at that edge.
  - bus_data_out is loaded for reads too; the value is don't-care.
- State machine (8-bit phase counter cnt):
  - IDLE: bus_en=0, rd=0, wr=0, req_ready=1. On accept → SETUP, cnt=SETUP_CYCLES-1.
  - SETUP: bus_en=1, strobes 0. When cnt==0 → STROBE, cnt=STROBE_CYCLES-1; else cnt-1.
  - STROBE: bus_en=1; bus_wr=is_write, bus_rd=~is_write. When cnt==0 → HOLD, cnt=HOLD_CYCLES-1. For reads, rdata<=bus_data_in on this same edge, i.e. the last STROBE cycle.
  - HOLD: bus_en=1, strobes 0. When cnt==0 → IDLE and done<=1.
- Output timing:
  - done is high for exactly one cycle, the first IDLE cycle.
  - req_ready is high during that cycle, so a new request may be accepted in the same cycle.
  - bus_en is therefore low for at least one full cycle between transactions.
  - Total latency: accept edge → done high = SETUP+STROBE+HOLD+1 cycles (5 with defaults).
- Stability rules:
  - bus_addr, bus_be and bus_data_out do not change from accept until the next accept.
  - bus_rd and bus_wr are never both high.
  - bus_rd and bus_wr are never high while bus_en=0.
- rdata holds its value until the next read completes; writes do not alter it.
- req_valid while busy: ignored (req_ready=0); the request is held by the requester.
- Reset mid-transaction (any non-IDLE state): next edge forces IDLE with all strobes 0 and no done pulse.
  - bus_en and bus_wr fall on the same edge. The register file is reset by the same system reset, so a spurious write edge is harmless.
- Bus outputs are driven directly from flops, with no combinational path from req_* to bus_*.

Test Plan:
- Write: req addr=0x0005, data=0xBEEF, be=2'b11, write=1 at cycle 0.
  - Required: bus_en high cycles 1-4; bus_wr high cycles 2-3; bus_rd always 0; bus_addr=0x0005, bus_data_out=0xBEEF throughout; done high only at cycle 5; req_ready low cycles 1-4.
- Read: req addr=0x0002 read, bus_data_in=0x1234 during STROBE.
  - Required: bus_rd high cycles 2-3; rdata=0x1234 from cycle 4; done at cycle 5; bus_wr always 0.
- Back-to-back: second request already valid when done=1.
  - Required: accepted in the done cycle; bus_en=0 for exactly that one cycle; the second transaction's bus_en rises the next cycle.
- Busy hold-off: req_valid held high during cycles 1-4.
  - Required: no accept (bus_addr unchanged) until the IDLE cycle; rdata unchanged by a following write.
- Reset mid-STROBE: assert reset at cycle 2 of a write.
  - Required: cycle 3 shows bus_en=0, bus_wr=0, req_ready=1, and done never pulses.
- Parameters SETUP=2, STROBE=3, HOLD=2 with be=2'b01.
  - Required: strobe high cycles 3-5; done at cycle 8; bus_be=2'b01 throughout.

Source files
------------

// File: rtl/reg_bus_initiator.sv
// Synchronous initiator for the asynchronous register bus: turns one valid/ready
// request into en/rd/wr strobes with programmable setup, strobe and hold phases.
module reg_bus_initiator #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_be,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bus_en,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [1:0]            bus_be,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  input  logic [DATA_WIDTH-1:0] bus_data_in
);

  // Handshake: a request transfers on the rising clk edge where req_valid and
  // req_ready are both high; the requester holds req_* stable until then.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       is_write;

  // Every bus output is a flop loaded with the value it must hold in the
  // state being entered, so nothing on the bus depends combinationally on req_*.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      is_write     <= 1'b0;
      req_ready    <= 1'b1;
      done         <= 1'b0;
      rdata        <= '0;
      bus_en       <= 1'b0;
      bus_rd       <= 1'b0;
      bus_wr       <= 1'b0;
      bus_be       <= 2'b00;
      bus_addr     <= '0;
      bus_data_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state        <= SETUP;
            cnt          <= SETUP_LOAD;
            is_write     <= req_write;
            bus_addr     <= req_addr;
            bus_data_out <= req_data;
            bus_be       <= req_be;
            bus_en       <= 1'b1;
            req_ready    <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state  <= STROBE;
            cnt    <= STROBE_LOAD;
            bus_wr <= is_write;
            bus_rd <= ~is_write;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STROBE: begin
          if (cnt == 8'd0) begin
            state  <= HOLD;
            cnt    <= HOLD_LOAD;
            bus_wr <= 1'b0;
            bus_rd <= 1'b0;
            // Sample on the last strobe cycle, once the register file has settled.
            if (!is_write) begin
              rdata <= bus_data_in;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            state     <= IDLE;
            bus_en    <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          bus_en    <= 1'b0;
          bus_rd    <= 1'b0;
          bus_wr    <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Bench for reg_bus_initiator: per-cycle vector table for the default build,
// plus hand-written sequences for a stretched-timing build and reset mid-strobe.
module tb_reg_bus_initiator;

  logic        clk;
  logic        reset;

  // default-parameter DUT
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_data;
  logic [1:0]  req_be;
  logic        done;
  logic [15:0] rdata;
  logic        bus_en, bus_rd, bus_wr;
  logic [1:0]  bus_be;
  logic [15:0] bus_addr, bus_data_out, bus_data_in;

  // SETUP=2 STROBE=3 HOLD=2 DUT
  logic        p_req_valid, p_req_ready, p_req_write;
  logic [15:0] p_req_addr, p_req_data;
  logic [1:0]  p_req_be;
  logic        p_done;
  logic [15:0] p_rdata;
  logic        p_bus_en, p_bus_rd, p_bus_wr;
  logic [1:0]  p_bus_be;
  logic [15:0] p_bus_addr, p_bus_data_out, p_bus_data_in;

  int errors = 0;
  int checks = 0;

  reg_bus_initiator u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .done(done), .rdata(rdata),
    .bus_en(bus_en), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_be(bus_be),
    .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in)
  );

  reg_bus_initiator #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u_dut_p (
    .clk(clk), .reset(reset),
    .req_valid(p_req_valid), .req_ready(p_req_ready), .req_write(p_req_write),
    .req_addr(p_req_addr), .req_data(p_req_data), .req_be(p_req_be),
    .done(p_done), .rdata(p_rdata),
    .bus_en(p_bus_en), .bus_rd(p_bus_rd), .bus_wr(p_bus_wr), .bus_be(p_bus_be),
    .bus_addr(p_bus_addr), .bus_data_out(p_bus_data_out), .bus_data_in(p_bus_data_in)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        write;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] din;
    logic [4:0]  flags;   // expected {bus_en, bus_rd, bus_wr, done, req_ready}
    logic [15:0] e_addr;
    logic [15:0] e_dout;
    logic [1:0]  e_be;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic valid, input logic write, input logic [15:0] addr,
                         input logic [15:0] data, input logic [1:0] be, input logic [15:0] din,
                         input logic [4:0] flags, input logic [15:0] e_addr,
                         input logic [15:0] e_dout, input logic [1:0] e_be,
                         input logic [15:0] e_rdata);
    vec_t v;
    v.valid = valid; v.write = write; v.addr = addr; v.data = data; v.be = be;
    v.din = din; v.flags = flags; v.e_addr = e_addr; v.e_dout = e_dout;
    v.e_be = e_be; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; req_be = 2'b00;
    bus_data_in = '0;
    p_req_valid = 1'b0; p_req_write = 1'b0; p_req_addr = '0; p_req_data = '0;
    p_req_be = 2'b00; p_bus_data_in = '0;
  endtask

  initial begin
    // table: one row per cycle; inputs applied in that cycle, outputs expected in it
    //      valid wr  addr     data     be     din       en rd wr dn rdy  addr     dout     be     rdata
    add_vec(1, 1, 16'h0005, 16'hBEEF, 2'b11, 16'h0000, 5'b00001, 16'h0000, 16'h0000, 2'b00, 16'h0000); // c0 accept write
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b10000, 16'h0005, 16'hBEEF, 2'b11, 16'h0000); // c1 setup
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b10100, 16'h0005, 16'hBEEF, 2'b11, 16'h0000); // c2 strobe
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b10100, 16'h0005, 16'hBEEF, 2'b11, 16'h0000); // c3 strobe
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b10000, 16'h0005, 16'hBEEF, 2'b11, 16'h0000); // c4 hold
    add_vec(1, 0, 16'h0002, 16'h0000, 2'b11, 16'h0000, 5'b00011, 16'h0005, 16'hBEEF, 2'b11, 16'h0000); // c5 done + read accept
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b10000, 16'h0002, 16'h0000, 2'b11, 16'h0000); // c6 setup
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h5555, 5'b11000, 16'h0002, 16'h0000, 2'b11, 16'h0000); // c7 strobe
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h1234, 5'b11000, 16'h0002, 16'h0000, 2'b11, 16'h0000); // c8 last strobe
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b10000, 16'h0002, 16'h0000, 2'b11, 16'h1234); // c9 hold
    add_vec(1, 1, 16'h000A, 16'h5A5A, 2'b10, 16'h0000, 5'b00011, 16'h0002, 16'h0000, 2'b11, 16'h1234); // c10 done + accept
    add_vec(1, 1, 16'h000B, 16'h7777, 2'b01, 16'h0000, 5'b10000, 16'h000A, 16'h5A5A, 2'b10, 16'h1234); // c11 busy, held req
    add_vec(1, 1, 16'h000B, 16'h7777, 2'b01, 16'h0000, 5'b10100, 16'h000A, 16'h5A5A, 2'b10, 16'h1234);
    add_vec(1, 1, 16'h000B, 16'h7777, 2'b01, 16'h0000, 5'b10100, 16'h000A, 16'h5A5A, 2'b10, 16'h1234);
    add_vec(1, 1, 16'h000B, 16'h7777, 2'b01, 16'h0000, 5'b10000, 16'h000A, 16'h5A5A, 2'b10, 16'h1234);
    add_vec(1, 1, 16'h000B, 16'h7777, 2'b01, 16'h0000, 5'b00011, 16'h000A, 16'h5A5A, 2'b10, 16'h1234); // c15 accept held
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b10000, 16'h000B, 16'h7777, 2'b01, 16'h1234);
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'hFFFF, 5'b10100, 16'h000B, 16'h7777, 2'b01, 16'h1234);
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'hFFFF, 5'b10100, 16'h000B, 16'h7777, 2'b01, 16'h1234);
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b10000, 16'h000B, 16'h7777, 2'b01, 16'h1234);
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b00011, 16'h000B, 16'h7777, 2'b01, 16'h1234); // c20 done
    add_vec(0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 5'b00001, 16'h000B, 16'h7777, 2'b01, 16'h1234); // c21 idle

    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    check("reset bus_en", 32'(bus_en), 32'd0);
    check("reset bus_rd", 32'(bus_rd), 32'd0);
    check("reset bus_wr", 32'(bus_wr), 32'd0);
    check("reset bus_be", 32'(bus_be), 32'd0);
    check("reset bus_addr", 32'(bus_addr), 32'd0);
    check("reset bus_data_out", 32'(bus_data_out), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("row%0d bus_en", i), 32'(bus_en), 32'(vecs[i].flags[4]));
      check($sformatf("row%0d bus_rd", i), 32'(bus_rd), 32'(vecs[i].flags[3]));
      check($sformatf("row%0d bus_wr", i), 32'(bus_wr), 32'(vecs[i].flags[2]));
      check($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].flags[1]));
      check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].flags[0]));
      check($sformatf("row%0d bus_addr", i), 32'(bus_addr), 32'(vecs[i].e_addr));
      check($sformatf("row%0d bus_data_out", i), 32'(bus_data_out), 32'(vecs[i].e_dout));
      check($sformatf("row%0d bus_be", i), 32'(bus_be), 32'(vecs[i].e_be));
      check($sformatf("row%0d rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
      req_valid   = vecs[i].valid;
      req_write   = vecs[i].write;
      req_addr    = vecs[i].addr;
      req_data    = vecs[i].data;
      req_be      = vecs[i].be;
      bus_data_in = vecs[i].din;
      @(negedge clk);
    end

    // stretched timing: SETUP=2, STROBE=3, HOLD=2, low byte only
    check("p idle req_ready", 32'(p_req_ready), 32'd1);
    p_req_valid = 1'b1; p_req_write = 1'b1; p_req_addr = 16'h0040;
    p_req_data = 16'h00FF; p_req_be = 2'b01;
    @(negedge clk);
    p_req_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("p c%0d bus_en", c), 32'(p_bus_en), 32'(c >= 1 && c <= 7));
      check($sformatf("p c%0d bus_wr", c), 32'(p_bus_wr), 32'(c >= 3 && c <= 5));
      check($sformatf("p c%0d bus_rd", c), 32'(p_bus_rd), 32'd0);
      check($sformatf("p c%0d done", c), 32'(p_done), 32'(c == 8));
      check($sformatf("p c%0d bus_be", c), 32'(p_bus_be), 32'h1);
      check($sformatf("p c%0d bus_addr", c), 32'(p_bus_addr), 32'h40);
      @(negedge clk);
    end

    // reset asserted during cycle 2 (first strobe cycle) of a write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0033; req_data = 16'hA5A5; req_be = 2'b11;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check("mid c2 bus_wr", 32'(bus_wr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid c3 bus_en", 32'(bus_en), 32'd0);
    check("mid c3 bus_wr", 32'(bus_wr), 32'd0);
    check("mid c3 req_ready", 32'(req_ready), 32'd1);
    check("mid c3 done", 32'(done), 32'd0);
    check("mid c3 bus_addr", 32'(bus_addr), 32'd0);
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("mid c%0d done", c), 32'(done), 32'd0);
      check($sformatf("mid c%0d bus_en", c), 32'(bus_en), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
